// File: rtl/freq_counter_avg_if.sv
// Measurement bus of freq_counter_avg: waveform, mode and clear in; result and status flags out.
// Master drives the stimulus side, slave is the counter itself.
interface freq_counter_avg_if #(
  parameter int CNT_W = 13
);
  logic             i_in_wave;
  logic             i_mode;
  logic             i_clear;
  logic [CNT_W-1:0] o_result;
  logic             o_result_valid;
  logic             o_filled;
  logic             o_stalled;

  modport master (
    output i_in_wave, i_mode, i_clear,
    input  o_result, o_result_valid, o_filled, o_stalled
  );

  modport slave (
    input  i_in_wave, i_mode, i_clear,
    output o_result, o_result_valid, o_filled, o_stalled
  );
endinterface

// File: rtl/freq_counter_avg.sv
// Frequency counter: sliding period average (mode 0) or gated edge count (mode 1) of an async waveform.
// Results registered 2 clocks after the synchronised rise; no backpressure, o_result_valid is a one-cycle strobe.
module freq_counter_avg #(
  parameter int CNT_W       = 13,
  parameter int LOG2_DEPTH  = 3,
  parameter int GATE_CYCLES = 50000,
  parameter int TIMEOUT     = 8191
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  freq_counter_avg_if.slave    bus
);
  localparam int DEPTH  = 1 << LOG2_DEPTH;
  localparam int SUM_W  = CNT_W + LOG2_DEPTH;
  localparam int GATE_W = $clog2(GATE_CYCLES);

  localparam logic [CNT_W-1:0]      TMO       = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = 1;
  localparam logic [GATE_W-1:0]     GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0]     GATE_ONE  = 1;
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = 1;
  localparam logic [LOG2_DEPTH:0]   FILL_ONE  = 1;
  localparam logic [LOG2_DEPTH:0]   FILL_FULL = (LOG2_DEPTH + 1)'(DEPTH);

  logic                  r_sync1, r_sync2, r_prev;
  logic                  r_mode_q;
  logic [CNT_W-1:0]      r_per;
  logic                  r_armed;
  logic [CNT_W-1:0]      r_buf [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH:0]   r_fill_cnt;
  logic [SUM_W-1:0]      r_sum;
  logic                  r_filled;
  logic                  r_stalled;
  logic [CNT_W-1:0]      r_result;
  logic                  r_valid;
  logic [GATE_W-1:0]     r_gate_cnt;
  logic [CNT_W-1:0]      r_edges;

  logic                  w_rise;
  logic                  w_restart;
  logic                  w_timeout;
  logic [SUM_W-1:0]      w_old;
  logic [SUM_W-1:0]      w_sum_new;
  logic [LOG2_DEPTH:0]   w_fill_new;
  logic [CNT_W-1:0]      w_avg;
  logic [CNT_W-1:0]      w_edges_inc;
  logic [CNT_W-1:0]      w_win_total;
  logic                  w_win_end;

  assign w_rise      = r_sync2 & ~r_prev;
  // A mode switch is treated exactly like clear so the two result types never mix.
  assign w_restart   = i_rst | bus.i_clear | (bus.i_mode != r_mode_q);
  assign w_timeout   = (r_per == TMO) & ~w_rise & ~r_stalled;
  assign w_old       = r_filled ? SUM_W'(r_buf[r_wr_ptr]) : '0;
  assign w_sum_new   = r_sum + SUM_W'(r_per) - w_old;
  assign w_fill_new  = r_filled ? r_fill_cnt : r_fill_cnt + FILL_ONE;
  assign w_avg       = CNT_W'(w_sum_new >> LOG2_DEPTH);
  assign w_edges_inc = (r_edges == CNT_MAX) ? r_edges : r_edges + CNT_ONE;
  assign w_win_total = w_rise ? w_edges_inc : r_edges;
  assign w_win_end   = (r_gate_cnt == GATE_LAST);

  always_ff @(posedge i_clk) begin
    if (w_restart) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_mode_q   <= bus.i_mode;
      r_per      <= '0;
      r_armed    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_sum      <= '0;
      r_filled   <= 1'b0;
      r_stalled  <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_gate_cnt <= '0;
      r_edges    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_sync1 <= bus.i_in_wave;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (w_rise)            r_per <= CNT_ONE;
      else if (r_per != TMO) r_per <= r_per + CNT_ONE;

      if (!r_mode_q) begin
        if (w_rise) begin
          // First rise after restart/stall only provides the reference edge.
          if (!r_armed) begin
            r_armed   <= 1'b1;
            r_stalled <= 1'b0;
          end else begin
            r_buf[r_wr_ptr] <= r_per;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            r_sum           <= w_sum_new;
            r_fill_cnt      <= w_fill_new;
            if (w_fill_new == FILL_FULL) begin
              r_filled <= 1'b1;
              r_result <= w_avg;
              r_valid  <= 1'b1;
            end
          end
        end else if (w_timeout) begin
          r_stalled  <= 1'b1;
          r_result   <= '0;
          r_valid    <= 1'b1;
          r_armed    <= 1'b0;
          r_fill_cnt <= '0;
          r_filled   <= 1'b0;
          r_sum      <= '0;
          r_wr_ptr   <= '0;
        end
      end else begin
        if (w_win_end) begin
          r_gate_cnt <= '0;
          r_result   <= w_win_total;
          r_valid    <= 1'b1;
          r_filled   <= 1'b1;
          r_stalled  <= (w_win_total == '0);
          r_edges    <= '0;
        end else begin
          r_gate_cnt <= r_gate_cnt + GATE_ONE;
          if (w_rise) r_edges <= w_edges_inc;
        end
      end
    end
  end

  assign bus.o_result       = r_result;
  assign bus.o_result_valid = r_valid;
  assign bus.o_filled       = r_filled;
  assign bus.o_stalled      = r_stalled;
endmodule

// File: tb/tb_freq_counter_avg.sv
// Directed bench for freq_counter_avg: period averaging, step response, timeout, clear priority,
// gated edge counting with last-cycle rise, mode toggle and reset while filled+stalled.
module tb_freq_counter_avg;
  localparam int CNT_W = 13;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   q_res[$];
  int   q_cyc[$];
  int   t_last, t_m, t_x, t_r;
  int   step_exp[10] = '{100, 95, 90, 85, 80, 75, 70, 65, 60, 60};

  freq_counter_avg_if #(.CNT_W(CNT_W)) bus ();

  freq_counter_avg #(
    .CNT_W(CNT_W), .LOG2_DEPTH(3), .GATE_CYCLES(1000), .TIMEOUT(1000)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Strobe log: value and edge index of every result_valid.
  always @(negedge i_clk) begin
    if (bus.o_result_valid) begin
      q_res.push_back(int'(bus.o_result));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qres(input int i);
    return (i < q_res.size()) ? q_res[i] : -1;
  endfunction

  function automatic int qcyc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wave(input int per, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_in_wave = 1'b1;
      for (int c = 0; c < per / 2; c++) tick();
      bus.i_in_wave = 1'b0;
      for (int c = per / 2; c < per; c++) tick();
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, bus.o_result, 0);
    chk({tag, "_valid"},  bus.o_result_valid, 0);
    chk({tag, "_filled"}, bus.o_filled, 0);
    chk({tag, "_stalled"}, bus.o_stalled, 0);
  endtask

  task automat_qclear();
  endtask

  initial begin
    i_rst         = 1'b1;
    bus.i_in_wave = 1'b0;
    bus.i_mode    = 1'b0;
    bus.i_clear   = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    i_rst = 1'b0;

    // Mode 0, period 100: nothing for 8 rises, then 100 per rise.
    wave(100, 8);
    chk("fill8_strobes", q_res.size(), 0);
    chk("fill8_filled", bus.o_filled, 0);
    wave(100, 4);
    chk("p100_strobes", q_res.size(), 4);
    chk("p100_first", qres(0), 100);
    chk("p100_last", qres(3), 100);
    chk("p100_filled", bus.o_filled, 1);
    chk("p100_hold", bus.o_result, 100);

    // Step to period 60; first new sample still spans a 100-clock period.
    q_res.delete(); q_cyc.delete();
    wave(60, 10);
    chk("step_strobes", q_res.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("step_%0d", i), qres(i), step_exp[i]);
    t_last = qcyc(9);

    // Timeout exactly 1000 clocks after the last accepted rise.
    q_res.delete(); q_cyc.delete();
    repeat (1100) tick();
    chk("tmo_strobes", q_res.size(), 1);
    chk("tmo_result", qres(0), 0);
    chk("tmo_delay", qcyc(0) - t_last, 1000);
    chk("tmo_stalled", bus.o_stalled, 1);
    chk("tmo_filled", bus.o_filled, 0);

    // Restart at period 50.
    q_res.delete(); q_cyc.delete();
    wave(50, 1);
    chk("rst50_stall_clr", bus.o_stalled, 0);
    chk("rst50_none", q_res.size(), 0);
    wave(50, 8);
    chk("rst50_strobes", q_res.size(), 1);
    chk("rst50_result", qres(0), 50);

    // Clear coinciding with a rise, mid-fill.
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    repeat (5) tick();
    wave(50, 3);
    bus.i_in_wave = 1'b1;
    tick(); tick();
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear   = 1'b0;
    bus.i_in_wave = 1'b0;
    chk_zero("clr_rise");
    q_res.delete(); q_cyc.delete();
    repeat (30) tick();
    wave(50, 8);
    chk("clr_refill_none", q_res.size(), 0);
    chk("clr_refill_filled", bus.o_filled, 0);
    wave(50, 1);
    chk("clr_refill_strobes", q_res.size(), 1);
    chk("clr_refill_result", qres(0), 50);

    // Mode 1: window of 1000 clocks, period 100.
    bus.i_mode = 1'b1;
    tick();
    t_m = cyc;
    chk_zero("m1_enter");
    q_res.delete(); q_cyc.delete();
    wave(100, 25);
    chk("m1_strobes", q_res.size(), 2);
    chk("m1_first_at", qcyc(0) - t_m, 1000);
    chk("m1_first", qres(0), 10);
    chk("m1_second", qres(1), 10);
    chk("m1_spacing", qcyc(1) - qcyc(0), 1000);
    chk("m1_filled", bus.o_filled, 1);
    chk("m1_stalled", bus.o_stalled, 0);

    // Rise acted on in the closing cycle counts in that window (5 + 1).
    q_res.delete(); q_cyc.delete();
    wait_to(t_m + 2997);
    bus.i_in_wave = 1'b1;
    wait_to(t_m + 3005);
    chk("m1_last_strobes", q_res.size(), 1);
    chk("m1_last_at", qcyc(0), t_m + 3000);
    chk("m1_last_count", qres(0), 6);

    // No edges: result 0 and stalled.
    q_res.delete(); q_cyc.delete();
    wait_to(t_m + 4005);
    chk("m1_zero_strobes", q_res.size(), 1);
    chk("m1_zero_result", qres(0), 0);
    chk("m1_zero_stalled", bus.o_stalled, 1);

    // Mode toggle mid-window: restart, no strobe; high input re-synchronises as one rise.
    q_res.delete(); q_cyc.delete();
    wait_to(t_m + 4500);
    bus.i_mode = 1'b0; tick();
    bus.i_mode = 1'b1; tick();
    t_x = cyc;
    chk_zero("toggle");
    chk("toggle_none", q_res.size(), 0);
    wait_to(t_x + 1005);
    chk("toggle_strobes", q_res.size(), 1);
    chk("toggle_at", qcyc(0), t_x + 1000);
    chk("toggle_count", qres(0), 1);
    wait_to(t_x + 2005);
    chk("pre_rst_stalled", bus.o_stalled, 1);
    chk("pre_rst_filled", bus.o_filled, 1);

    // Reset with filled and stalled both set, then resume.
    i_rst = 1'b1;
    tick();
    chk_zero("rst_busy");
    i_rst = 1'b0;
    t_r = cyc;
    q_res.delete(); q_cyc.delete();
    wave(100, 12);
    chk("resume_strobes", q_res.size(), 1);
    chk("resume_at", qcyc(0), t_r + 1000);
    chk("resume_count", qres(0), 10);
    chk("resume_stalled", bus.o_stalled, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/freq_counter_avg.md
# freq_counter_avg

Parametrised successor frequency counter for measuring Superchip sample outputs on the Cyclone IV tester. It synchronises an asynchronous `in_wave`, detects rising edges and reports one of two results, selected by `mode`. Mode 0 reports a sliding average of the last 2^LOG2_DEPTH periods, in clock cycles. Mode 1 reports the edge count over a fixed gate window. It adds stall detection, a result-valid strobe and a synchronous clear, and sits between the DUT output pin and the result readout logic.

## Interface
- CNT_W, 13: width of period/edge counters and `result`.
- LOG2_DEPTH, 3: averaging depth is 2^LOG2_DEPTH samples (1..6).
- GATE_CYCLES, 50000: gate window length in clocks, mode 1 (≥2).
- TIMEOUT, 8191: clocks without a rising edge before stall; 2 ≤ TIMEOUT ≤ 2^CNT_W−1.

Ports:
- Clock  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- in_wave  input  1  asynchronous measured waveform.
- mode  input  1  0 = period average, 1 = gated edge count.
- clear  input  1  synchronous restart, same effect as Reset.
- result  output  CNT_W  averaged period (mode 0) or edge count (mode 1).
- result_valid  output  1  one-cycle strobe when `result` is updated.
- filled  output  1  mode 0: buffer holds 2^LOG2_DEPTH samples; mode 1: at least one window completed.
- stalled  output  1  mode 0: timeout active; mode 1: last window counted 0 edges.

## Operation
- Synchroniser: `sync1 → sync2 → prev` registers. `rise = sync2 & ~prev`.
- Period counter `per`, CNT_W bits. On `rise`, `per <= 1`; otherwise `per <= per+1`, saturating at TIMEOUT.
- Mode 0, `rise` while unarmed: the rise only arms the block and clears `stalled`. No sample is pushed.
- Mode 0, `rise` while armed: `sample = per` (clocks since the previous rise).
  - Write `sample` to `buf[wr_ptr]`; `wr_ptr` wraps mod 2^LOG2_DEPTH.
  - `sum <= sum + sample − (filled ? buf[wr_ptr] : 0)`. `sum` is CNT_W+LOG2_DEPTH bits and cannot overflow.
  - `fill_cnt` increments until 2^LOG2_DEPTH, which sets `filled`.
  - If `filled` holds after this push, `result <= sum_new >> LOG2_DEPTH` (truncating), using the updated sum, and `result_valid` pulses.
- Mode 0 timeout: when `per == TIMEOUT`, `rise` is 0 and `stalled` is 0:
  - `stalled <= 1`, `result <= 0`, `result_valid` pulses once.
  - `armed`, `fill_cnt`, `filled`, `sum` and `wr_ptr` all go to 0.
  - While stalled, `per` holds at TIMEOUT and no further pulses occur.
  - Timeout also applies before the first edge after reset.
- Mode 1:
  - `gate_cnt` counts 0..GATE_CYCLES−1 and wraps.
  - `edges` counts rises and saturates at 2^CNT_W−1.
  - In the cycle where `gate_cnt == GATE_CYCLES−1`, the window closes:
    - `result <= edges + rise` (saturating); a rise in the last cycle counts in the closing window.
    - `result_valid` pulses; `filled <= 1`; `stalled <= (result_new == 0)`; `edges <= 0`.
- Mode change: `mode` is registered into `mode_q`. `mode != mode_q` acts as `clear` in that cycle and produces no `result_valid`.
- Reset/clear: returns every register to its reset value.
  - Outputs: `result` 0, `result_valid` 0, `filled` 0, `stalled` 0.
  - Internal: sync regs 0, `per` 0, `gate_cnt` 0, `edges` 0, unarmed.
  - Takes priority over `rise`, timeout and window close in the same cycle.

## Timing
- `in_wave` goes high before edge t: `rise` is true in the cycle after edge t+1 and is acted on at edge t+2. `result`/`result_valid` are registered outputs updated at t+2.
- Period sample = exact clock count between accepted rises. Input jitter of ±1 cycle comes from the synchroniser.
- First mode-0 `result_valid` comes at the (2^LOG2_DEPTH + 1)-th rise after reset, clear or stall.
- Timeout is acted on at the edge TIMEOUT cycles after the last accepted rise edge.
- Mode 1 `result_valid` occurs every GATE_CYCLES clocks. The first one comes GATE_CYCLES edges after reset or clear.
- `result` holds its value between strobes. `result_valid` is never high two cycles running in mode 0 unless consecutive rises are 1 clock apart, which cannot happen.

## Test plan
- Mode 0, defaults, square wave period 100 clocks: no valid for the first 8 rises. The 9th rise gives `result`=100, `filled`=1, then one strobe per rise at 100.
- Step period 100→60 after filled: successive results 95, 90, 85, 80, 75, 70, 65, 60, then steady at 60.
- TIMEOUT=1000, stop `in_wave` after filled: exactly 1000 clocks after the last rise, `stalled`=1, `result`=0, single strobe, `filled`=0. On restart at period 50, `stalled` clears at the first rise, and the next strobe is `result`=50 at the 9th rise.
- Mode 1, GATE_CYCLES=1000, period 100: `result`=10 every 1000 clocks. With a rise aligned to the last gate cycle, that rise counts in the closing window. No input gives `result`=0 and `stalled`=1.
- Assert `clear` in the same cycle as a rise, mid-fill: next cycle all outputs are at reset values and the rise is ignored. Toggling `mode` mid-window restarts with no strobe.
- Assert `Reset` with `filled`=1 and `stalled`=1: all outputs are 0 next cycle, and operation resumes correctly after release.
